// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared types, key map and helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_e;

  // First column driven low after reset; rotation walks the zero upward.
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Hex code of each key, indexed by {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Lowest-numbered low row wins when several rows are pulled down.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Position of the single zero in a one-cold column pattern.
  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) c = 2'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and digit display signal bundle
interface keypad_scanner_if;
  logic       clr;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] key;
  logic       key_valid;
  logic [3:0] Dig0;
  logic [3:0] Dig1;
  logic [3:0] Dig2;
  logic [3:0] Dig3;

  // Scanner side: senses rows, drives columns, key and digits.
  modport master (
    input  clr, Row,
    output Col, key, key_valid, Dig0, Dig1, Dig2, Dig3
  );

  // Keypad / display side.
  modport slave (
    output clr, Row,
    input  Col, key, key_valid, Dig0, Dig1, Dig2, Dig3
  );
endinterface

// File: rtl/keypad_scanner_scan_tick.sv
// rtl/keypad_scanner_scan_tick.sv - column dwell divider producing a one-cycle tick
module scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Free-running 0..SCAN_DIV-1 counter.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce and 4-digit shift register
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic            clk,
  input  logic            reset,
  keypad_scanner_if.master kp
);

  localparam int CW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS);
  localparam bit DB_ONE = (DEBOUNCE_TICKS == 1);

  logic            tick;
  logic [3:0]      row_meta_q;
  logic [3:0]      rs_q;
  kp_state_e       state_q, state_d;
  logic [3:0]      col_q, col_d;
  logic [1:0]      lat_row_q, lat_row_d;
  logic [1:0]      lat_col_q, lat_col_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0][3:0] dig_q, dig_d;

  logic            rows_idle;
  logic [CW-1:0]   cnt_inc;
  logic            accept;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk    (clk),
    .rst_n  (reset),
    .tick_o (tick)
  );

  // Two-flop synchronizer on the asynchronous row inputs; idle is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'b1111;
      rs_q       <= 4'b1111;
    end else begin
      row_meta_q <= kp.Row;
      rs_q       <= row_meta_q;
    end
  end

  // Next-state logic: scan rotation, press/release debounce, key acceptance.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    dig_d       = dig_q;
    accept      = 1'b0;
    rows_idle   = &rs_q;
    cnt_inc     = cnt_q + CW'(1);

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (rows_idle) begin
            col_d = {col_q[2:0], col_q[3]};
          end else begin
            // Column stays frozen on the key's column from here on.
            lat_row_d = low_row(rs_q);
            lat_col_d = col_index(col_q);
            cnt_d     = CW'(1);
            if (DB_ONE) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (!rs_q[lat_row_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (rows_idle) begin
            cnt_d   = CW'(1);
            state_d = DB_ONE ? ST_SCAN : ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (rows_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) state_d = ST_SCAN;
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    if (accept) begin
      key_valid_d = 1'b1;
      key_d       = KEY_MAP[{lat_row_d, lat_col_d}];
      dig_d       = {dig_q[2:0], KEY_MAP[{lat_row_d, lat_col_d}]};
    end

    // Clear wins over a same-cycle shift; key and strobe still update.
    if (kp.clr) dig_d = '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      col_q       <= COL_RESET;
      lat_row_q   <= 2'd0;
      lat_col_q   <= 2'd0;
      cnt_q       <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      dig_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      dig_q       <= dig_d;
    end
  end

  assign kp.Col       = col_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.Dig0      = dig_q[0];
  assign kp.Dig1      = dig_q[1];
  assign kp.Dig2      = dig_q[2];
  assign kp.Dig3      = dig_q[3];

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex keypad (active-low columns driven, active-low rows sensed) and turns debounced key presses into hex digits. Each accepted key produces a one-cycle `key_valid` strobe and shifts into a 4-digit register. The digit outputs connect directly to the `Dig0`–`Dig3` inputs of the seven-segment display block, so typed keys scroll in from the right.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per column dwell (1 ms at 50 MHz); minimum 4.
- `DEBOUNCE_TICKS`, default 8: consecutive confirming scan ticks required for press and for release; minimum 1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous, active-high; zeroes `Dig0`–`Dig3`.
- `Row` input 4: keypad rows; active-low, externally pulled up.
- `Col` output 4: keypad columns; one-cold while scanning.
- `key` output 4: hex code of the most recently accepted key.
- `key_valid` output 1: one-cycle strobe on key acceptance.
- `Dig0`–`Dig3` output 4 each: digit shift register; `Dig0` is the newest digit.

## Operation
- `Row` passes through a 2-FF synchronizer; all logic below sees only the synchronized rows `rs`.
- A tick counter runs 0..SCAN_DIV-1, and `tick` is asserted when the counter equals SCAN_DIV-1. Logic acts only on `tick` cycles.
- Key map, indexed [row][col]:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- If more than one row is low, the lowest row index wins.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
  - SCAN: on `tick`, if `rs` is all ones, rotate `Col` (1110→1101→1011→0111→1110). Otherwise latch the column/row pair, freeze `Col`, set the debounce count to 1, and go to PRESS_DB.
  - PRESS_DB: on `tick`, if the latched row is still low, increment the count. When the count reaches DEBOUNCE_TICKS, assert `key_valid`, load `key`, shift digits (Dig3←Dig2, Dig2←Dig1, Dig1←Dig0, Dig0←key), and go to HELD. If the latched row is high, clear the count and return to SCAN, resuming rotation from the frozen column.
  - HELD: `Col` stays frozen. On `tick`, if `rs` is all ones, set the count to 1 and go to RELEASE_DB.
  - RELEASE_DB: on `tick`, all-ones `rs` increments the count. Reaching DEBOUNCE_TICKS returns to SCAN. Any low row returns to HELD; no new strobe is issued.
- If DEBOUNCE_TICKS = 1, acceptance and release happen on the first detecting tick, with no PRESS_DB/RELEASE_DB dwell.
- `clr` has priority over a same-cycle shift: digits become 0, but `key` and `key_valid` still update.
- Reset values: state SCAN, `Col`=4'b1110, `key`=0, `key_valid`=0, `Dig0`–`Dig3`=0, tick counter 0, synchronizer 4'b1111.
- Reset asserted mid-debounce discards the pending key. No strobe is issued after reset deasserts unless a fresh press completes debounce.

## Timing
- `Row` to `rs` latency is 2 cycles. `Col` is registered, so rows settle during the dwell of SCAN_DIV ≥ 4 cycles before sampling.
- `key_valid`, `key` and the digits update in the cycle after the DEBOUNCE_TICKS-th confirming tick, counting the detecting tick as the first.
- Press-to-strobe time: at most (DEBOUNCE_TICKS+4)·SCAN_DIV + 3 cycles.
- Exactly one strobe per physical press. Holding a key does not auto-repeat.
- `key_valid` is never high for two consecutive cycles.

## Structure
- Package `keypad_pkg` holds:
  - FSM state enum
  - 16-entry key-map constant
  - column reset constant 4'b1110
- Sub-module `scan_tick` is a parameterized divider (SCAN_DIV) producing a single-cycle `tick`, with async active-low reset.
- The FSM, synchronizer and digit register live in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_TICKS=3. The bench models the keypad by driving `Row` low only while the pressed key's column is low.
- Reset: hold `reset`=0 → `Col`=1110, `Dig0`–`Dig3`=0, `key_valid`=0; release → `Col` rotates every 4 cycles.
- Single press of "5" (row 1, col 1), held 10 ticks → exactly one `key_valid` pulse with `key`=5 and `Dig0`=5; other digits stay 0.
- Press sequence 1, 2, 3, A with debounced releases between → `Dig3`..`Dig0` = 1, 2, 3, A; a fifth key "0" gives 2, 3, A, 0.
- Bounce: row low for 2 ticks, then high → no `key_valid`, FSM returns to SCAN, and `Col` resumes rotating from the frozen column.
- Two rows low in column 2 (rows 1 and 3) → `key`=6. A release glitch of 1 tick inside HELD → no second strobe.
- `reset` pulsed low during PRESS_DB, key held throughout → outputs return to reset values; after release, one strobe follows a full re-debounce. `clr` coinciding with `key_valid` → all digits 0 and `key` updated.
